// File: rtl/decode_pkg.sv
// Shared decode encodings: opcodes, branch funct3, ALU and WB selects,
// and the control bundle handed from decode to execute.
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // WB_TGT writes back id_target (pc + imm), which is how AUIPC retires.
  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC4 = 3'd2;
  localparam logic [2:0] WB_IMM = 3'd3;
  localparam logic [2:0] WB_TGT = 3'd4;

  typedef struct packed {
    logic       reg_we;
    logic [2:0] wb_sel;
    logic       mem_we;
    logic       alu_src;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_S,
    FMT_B, FMT_U, FMT_J
  } fmt_e;

  function automatic ctrl_t mk_ctrl(
    input logic       we,
    input logic [2:0] wb,
    input logic       mw,
    input logic       src,
    input logic [3:0] alu
  );
    ctrl_t c;
    c.reg_we   = we;
    c.wb_sel   = wb;
    c.mem_we   = mw;
    c.alu_src  = src;
    c.alu_ctrl = alu;
    return c;
  endfunction

  function automatic logic [3:0] alu_of(
    input logic [2:0] f3,
    input logic       f7b5,
    input logic       is_op
  );
    logic [3:0] a;
    a = ALU_ADD;
    unique case (f3)
      3'd0: a = (is_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'd1: a = ALU_SLL;
      3'd2: a = ALU_SLT;
      3'd3: a = ALU_SLTU;
      3'd4: a = ALU_XOR;
      3'd5: a = f7b5 ? ALU_SRA : ALU_SRL;
      3'd6: a = ALU_OR;
      3'd7: a = ALU_AND;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/decode_stage_p_regfile.sv
// NREG x XLEN register file, two combinational read ports, one write
// port, optional same-cycle WB bypass. x0 is hardwired to zero.
module regfile_p #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int BYPASS_WB = 1
) (
  input  logic            clk,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] r_mem [NREG];
  logic            w_wr;
  logic            w_rng_w;
  logic            w_rng_1;
  logic            w_rng_2;

  assign w_rng_w = 32'(waddr)  < 32'(NREG);
  assign w_rng_1 = 32'(raddr1) < 32'(NREG);
  assign w_rng_2 = 32'(raddr2) < 32'(NREG);
  assign w_wr    = we && (waddr != 5'd0) && w_rng_w;

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[waddr[AW-1:0]] <= wdata;
  end

  always_comb begin
    rdata1 = r_mem[raddr1[AW-1:0]];
    if (raddr1 == 5'd0 || !w_rng_1)
      rdata1 = '0;
    else if (BYPASS_WB != 0 && w_wr && waddr == raddr1)
      rdata1 = wdata;
  end

  always_comb begin
    rdata2 = r_mem[raddr2[AW-1:0]];
    if (raddr2 == 5'd0 || !w_rng_2)
      rdata2 = '0;
    else if (BYPASS_WB != 0 && w_wr && waddr == raddr2)
      rdata2 = wdata;
  end

endmodule

// File: rtl/decode_stage_p.sv
// RV32I/E decode stage: decoder, imm-gen, early branch/jump resolve,
// load-use hazard detect, ID/EX register and hazard-stall counter.
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int BYPASS_WB = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_pc4,
  input  logic            wb_we,
  input  logic [4:0]      wb_waddr,
  input  logic [XLEN-1:0] wb_wdata,
  input  logic            ex_load,
  input  logic [4:0]      ex_rd,
  input  logic            stall_in,
  input  logic            flush,
  output logic            stall_req,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_target,
  output logic            id_valid,
  output ctrl_t           id_ctrl,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_rs1_data,
  output logic [XLEN-1:0] id_rs2_data,
  output logic [XLEN-1:0] id_imm,
  output logic [XLEN-1:0] id_pc4,
  output logic [XLEN-1:0] id_target,
  output logic [31:0]     stall_cnt
);

  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_rs1_d;
  logic [XLEN-1:0] w_rs2_d;
  ctrl_t           w_ctrl_raw;
  ctrl_t           w_ctrl;
  fmt_e            w_fmt;
  logic            w_ok;
  logic            w_legal;
  logic            w_use1;
  logic            w_use2;
  logic            w_used;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_target;
  logic            w_taken;
  logic            w_jump;
  logic            w_hazard;

  assign w_op  = if_instr[6:0];
  assign w_f3  = if_instr[14:12];
  assign w_f7  = if_instr[31:25];
  assign w_rd  = if_instr[11:7];
  assign w_rs1 = if_instr[19:15];
  assign w_rs2 = if_instr[24:20];

  regfile_p #(
    .XLEN      (XLEN),
    .NREG      (NREG),
    .BYPASS_WB (BYPASS_WB)
  ) u_rf (
    .clk    (clk),
    .we     (wb_we),
    .waddr  (wb_waddr),
    .wdata  (wb_wdata),
    .raddr1 (w_rs1),
    .raddr2 (w_rs2),
    .rdata1 (w_rs1_d),
    .rdata2 (w_rs2_d)
  );

  always_comb begin
    w_ctrl_raw = '0;
    w_fmt      = FMT_NONE;
    w_ok       = 1'b0;
    unique case (1'b1)
      (w_op == OP_LUI): begin
        w_fmt      = FMT_U;
        w_ok       = 1'b1;
        w_ctrl_raw = mk_ctrl(1'b1, WB_IMM, 1'b0, 1'b1, ALU_ADD);
      end
      (w_op == OP_AUIPC): begin
        w_fmt      = FMT_U;
        w_ok       = 1'b1;
        w_ctrl_raw = mk_ctrl(1'b1, WB_TGT, 1'b0, 1'b1, ALU_ADD);
      end
      (w_op == OP_JAL): begin
        w_fmt      = FMT_J;
        w_ok       = 1'b1;
        w_ctrl_raw = mk_ctrl(1'b1, WB_PC4, 1'b0, 1'b1, ALU_ADD);
      end
      (w_op == OP_JALR): begin
        w_fmt      = FMT_I;
        w_ok       = (w_f3 == 3'd0);
        w_ctrl_raw = mk_ctrl(1'b1, WB_PC4, 1'b0, 1'b1, ALU_ADD);
      end
      (w_op == OP_BRANCH): begin
        w_fmt      = FMT_B;
        w_ok       = (w_f3 != 3'd2) && (w_f3 != 3'd3);
        w_ctrl_raw = mk_ctrl(1'b0, WB_ALU, 1'b0, 1'b0, ALU_SUB);
      end
      (w_op == OP_LOAD): begin
        w_fmt      = FMT_I;
        w_ok       = (w_f3 != 3'd3) && (w_f3 < 3'd6);
        w_ctrl_raw = mk_ctrl(1'b1, WB_MEM, 1'b0, 1'b1, ALU_ADD);
      end
      (w_op == OP_STORE): begin
        w_fmt      = FMT_S;
        w_ok       = (w_f3 < 3'd3);
        w_ctrl_raw = mk_ctrl(1'b0, WB_ALU, 1'b1, 1'b1, ALU_ADD);
      end
      (w_op == OP_OPIMM): begin
        w_fmt      = FMT_I;
        w_ok       = (w_f3 == 3'd1) ? (w_f7 == 7'h00) :
                     (w_f3 == 3'd5) ? (w_f7 == 7'h00 || w_f7 == 7'h20) :
                     1'b1;
        w_ctrl_raw = mk_ctrl(1'b1, WB_ALU, 1'b0, 1'b1,
                             alu_of(w_f3, w_f7[5], 1'b0));
      end
      (w_op == OP_OP): begin
        w_fmt      = FMT_R;
        w_ok       = (w_f7 == 7'h00) ||
                     (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5));
        w_ctrl_raw = mk_ctrl(1'b1, WB_ALU, 1'b0, 1'b0,
                             alu_of(w_f3, w_f7[5], 1'b1));
      end
      default: ;
    endcase
  end

  assign w_use1 = (w_fmt == FMT_R) || (w_fmt == FMT_I) ||
                  (w_fmt == FMT_S) || (w_fmt == FMT_B);
  assign w_use2 = (w_fmt == FMT_R) || (w_fmt == FMT_S) ||
                  (w_fmt == FMT_B);
  assign w_used = (w_fmt == FMT_R) || (w_fmt == FMT_I) ||
                  (w_fmt == FMT_U) || (w_fmt == FMT_J);

  // Registers beyond NREG (RV32E) make the whole instruction illegal.
  assign w_legal = w_ok &&
    (!w_used || 32'(w_rd)  < 32'(NREG)) &&
    (!w_use1 || 32'(w_rs1) < 32'(NREG)) &&
    (!w_use2 || 32'(w_rs2) < 32'(NREG));
  assign w_ctrl = w_legal ? w_ctrl_raw : '0;

  always_comb begin
    w_imm32 = '0;
    unique case (w_fmt)
      FMT_I: w_imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
      FMT_S: w_imm32 = {{20{if_instr[31]}}, if_instr[31:25],
                        if_instr[11:7]};
      FMT_B: w_imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                        if_instr[30:25], if_instr[11:8], 1'b0};
      FMT_U: w_imm32 = {if_instr[31:12], 12'd0};
      FMT_J: w_imm32 = {{11{if_instr[31]}}, if_instr[31],
                        if_instr[19:12], if_instr[20],
                        if_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign w_imm = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

  always_comb begin
    w_taken = 1'b0;
    unique case (w_f3)
      F3_BEQ:  w_taken = (w_rs1_d == w_rs2_d);
      F3_BNE:  w_taken = (w_rs1_d != w_rs2_d);
      F3_BLT:  w_taken = ($signed(w_rs1_d) <  $signed(w_rs2_d));
      F3_BGE:  w_taken = ($signed(w_rs1_d) >= $signed(w_rs2_d));
      F3_BLTU: w_taken = (w_rs1_d <  w_rs2_d);
      F3_BGEU: w_taken = (w_rs1_d >= w_rs2_d);
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_target = if_pc + w_imm;
    if (w_op == OP_JALR) begin
      w_target    = w_rs1_d + w_imm;
      w_target[0] = 1'b0;
    end
  end

  assign w_jump = w_legal && ((w_op == OP_JAL) || (w_op == OP_JALR) ||
                  (w_op == OP_BRANCH && w_taken));

  assign w_hazard = if_valid && ex_load && (ex_rd != 5'd0) &&
                    ((w_use1 && w_rs1 == ex_rd) ||
                     (w_use2 && w_rs2 == ex_rd));

  assign stall_req       = w_hazard && !flush;
  assign redirect        = if_valid && !w_hazard && !flush &&
                           !stall_in && w_jump;
  assign redirect_target = w_target;

  logic            r_valid;
  ctrl_t           r_ctrl;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc4;
  logic [XLEN-1:0] r_tgt;
  logic [31:0]     r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_instr <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_imm   <= '0;
      r_pc4   <= '0;
      r_tgt   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (stall_in) begin
      r_valid <= r_valid;
    end else if (w_hazard) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      r_valid <= if_valid;
      r_ctrl  <= if_valid ? w_ctrl : '0;
      r_instr <= if_instr;
      r_rs1   <= w_rs1_d;
      r_rs2   <= w_rs2_d;
      r_imm   <= w_imm;
      r_pc4   <= if_pc4;
      r_tgt   <= w_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (stall_req && !stall_in && r_cnt != 32'hFFFF_FFFF)
      r_cnt <= r_cnt + 32'd1;
  end

  assign id_valid    = r_valid;
  assign id_ctrl     = r_ctrl;
  assign id_instr    = r_instr;
  assign id_rs1_data = r_rs1;
  assign id_rs2_data = r_rs2;
  assign id_imm      = r_imm;
  assign id_pc4      = r_pc4;
  assign id_target   = r_tgt;
  assign stall_cnt   = r_cnt;

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p: default, no-bypass and RV32E
// instances share one stimulus stream.
module tb_decode_stage_p;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc4;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        ex_load;
  logic [4:0]  ex_rd;
  logic        stall_in, flush;

  logic        sr [3];
  logic        rd [3];
  logic [31:0] rt [3];
  logic        v  [3];
  ctrl_t       c  [3];
  logic [31:0] ins[3], r1[3], r2[3], im[3], p4[3], tg[3], sc[3];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decode_stage_p #(.XLEN(32), .NREG(32), .BYPASS_WB(1)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ex_load(ex_load), .ex_rd(ex_rd), .stall_in(stall_in),
    .flush(flush), .stall_req(sr[0]), .redirect(rd[0]),
    .redirect_target(rt[0]), .id_valid(v[0]), .id_ctrl(c[0]),
    .id_instr(ins[0]), .id_rs1_data(r1[0]), .id_rs2_data(r2[0]),
    .id_imm(im[0]), .id_pc4(p4[0]), .id_target(tg[0]),
    .stall_cnt(sc[0]));

  decode_stage_p #(.XLEN(32), .NREG(32), .BYPASS_WB(0)) dut_nb (
    .clk(clk), .reset(reset), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ex_load(ex_load), .ex_rd(ex_rd), .stall_in(stall_in),
    .flush(flush), .stall_req(sr[1]), .redirect(rd[1]),
    .redirect_target(rt[1]), .id_valid(v[1]), .id_ctrl(c[1]),
    .id_instr(ins[1]), .id_rs1_data(r1[1]), .id_rs2_data(r2[1]),
    .id_imm(im[1]), .id_pc4(p4[1]), .id_target(tg[1]),
    .stall_cnt(sc[1]));

  decode_stage_p #(.XLEN(32), .NREG(16), .BYPASS_WB(1)) dut16 (
    .clk(clk), .reset(reset), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ex_load(ex_load), .ex_rd(ex_rd), .stall_in(stall_in),
    .flush(flush), .stall_req(sr[2]), .redirect(rd[2]),
    .redirect_target(rt[2]), .id_valid(v[2]), .id_ctrl(c[2]),
    .id_instr(ins[2]), .id_rs1_data(r1[2]), .id_rs2_data(r2[2]),
    .id_imm(im[2]), .id_pc4(p4[2]), .id_target(tg[2]),
    .stall_cnt(sc[2]));

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic we, input logic [4:0] a,
                    input logic [31:0] d);
    wb_we    = we;
    wb_waddr = a;
    wb_wdata = d;
  endtask

  ctrl_t k_addi, k_add;
  logic [31:0] k_ins_add;

  initial begin
    k_addi = '{reg_we: 1'b1, wb_sel: WB_ALU, mem_we: 1'b0,
               alu_src: 1'b1, alu_ctrl: ALU_ADD};
    k_add  = '{reg_we: 1'b1, wb_sel: WB_ALU, mem_we: 1'b0,
               alu_src: 1'b0, alu_ctrl: ALU_ADD};
    k_ins_add = 32'h0062_02B3;
    reset = 1'b1; if_valid = 1'b0; if_instr = '0;
    if_pc = '0; if_pc4 = '0; wb(1'b0, 5'd0, '0);
    ex_load = 1'b0; ex_rd = '0; stall_in = 1'b0; flush = 1'b0;
    repeat (2) step();
    chk("rst_valid", 64'(v[0]), 64'd0);
    chk("rst_ctrl", 64'(c[0]), 64'd0);
    chk("rst_imm", 64'(im[0]), 64'd0);
    chk("rst_rs1", 64'(r1[0]), 64'd0);
    chk("rst_cnt", 64'(sc[0]), 64'd0);

    reset = 1'b0;
    if_valid = 1'b1; if_instr = 32'h0050_0093;
    if_pc = 32'h0; if_pc4 = 32'h4;
    wb(1'b1, 5'd1, 32'd5);
    step();
    chk("addi_valid", 64'(v[0]), 64'd1);
    chk("addi_imm", 64'(im[0]), 64'd5);
    chk("addi_ctrl", 64'(c[0]), 64'(k_addi));
    chk("addi_pc4", 64'(p4[0]), 64'd4);

    if_instr = 32'h0000_8113; wb(1'b0, 5'd0, '0);
    step();
    chk("x1_byp", 64'(r1[0]), 64'd5);
    chk("x1_nobyp", 64'(r1[1]), 64'd5);

    if_instr = 32'h0003_8193; wb(1'b1, 5'd7, 32'h77);
    step();
    chk("wb_bypass", 64'(r1[0]), 64'h77);
    wb(1'b0, 5'd0, '0);
    step();
    chk("x7_nobyp", 64'(r1[1]), 64'h77);

    if_valid = 1'b0;
    wb(1'b1, 5'd1, 32'd7);     step();
    wb(1'b1, 5'd2, 32'd7);     step();
    wb(1'b1, 5'd3, 32'h200);   step();
    wb(1'b0, 5'd0, '0);

    if_valid = 1'b1; if_instr = 32'h0020_8863;
    if_pc = 32'h100; if_pc4 = 32'h104;
    #1;
    chk("beq_redir", 64'(rd[0]), 64'd1);
    chk("beq_tgt", 64'(rt[0]), 64'h110);
    chk("beq_stall", 64'(sr[0]), 64'd0);
    wb(1'b1, 5'd2, 32'd8);
    step();
    chk("beq_idtgt", 64'(tg[0]), 64'h110);
    wb(1'b0, 5'd0, '0);
    #1;
    chk("bne_redir", 64'(rd[0]), 64'd0);

    if_instr = 32'h0031_8067; if_pc = 32'h200; if_pc4 = 32'h204;
    #1;
    chk("jalr_redir", 64'(rd[0]), 64'd1);
    chk("jalr_tgt", 64'(rt[0]), 64'h202);
    step();

    ex_load = 1'b1; ex_rd = 5'd4; if_instr = k_ins_add;
    #1;
    chk("haz_req", 64'(sr[0]), 64'd1);
    chk("haz_redir", 64'(rd[0]), 64'd0);
    step();
    chk("haz_bubble", 64'(v[0]), 64'd0);
    chk("haz_cnt", 64'(sc[0]), 64'd1);

    if_instr = 32'h1234_5237;
    #1;
    chk("lui_nohaz", 64'(sr[0]), 64'd0);
    step();
    chk("lui_valid", 64'(v[0]), 64'd1);
    chk("lui_imm", 64'(im[0]), 64'h1234_5000);
    chk("lui_cnt", 64'(sc[0]), 64'd1);

    ex_load = 1'b0; if_instr = k_ins_add;
    step();
    chk("add_ctrl", 64'(c[0]), 64'(k_add));
    stall_in = 1'b1; if_instr = 32'h0050_0093;
    step();
    chk("hold_instr", 64'(ins[0]), 64'(k_ins_add));
    chk("hold_valid", 64'(v[0]), 64'd1);
    chk("hold_ctrl", 64'(c[0]), 64'(k_add));
    flush = 1'b1;
    step();
    chk("fl_valid", 64'(v[0]), 64'd0);
    chk("fl_ctrl", 64'(c[0]), 64'd0);
    chk("fl_instr", 64'(ins[0]), 64'(k_ins_add));
    flush = 1'b0;
    step();
    chk("hold3_valid", 64'(v[0]), 64'd0);

    ex_load = 1'b1; ex_rd = 5'd4; if_instr = k_ins_add;
    #1;
    chk("stl_haz_req", 64'(sr[0]), 64'd1);
    step();
    chk("stl_haz_cnt", 64'(sc[0]), 64'd1);
    stall_in = 1'b0; flush = 1'b1;
    #1;
    chk("fl_haz_req", 64'(sr[0]), 64'd0);
    step();
    chk("fl_haz_cnt", 64'(sc[0]), 64'd1);
    flush = 1'b0; ex_load = 1'b0;

    if_instr = 32'h0000_0113; wb(1'b1, 5'd0, 32'hDEAD);
    step();
    chk("x0_byp", 64'(r1[0]), 64'd0);
    wb(1'b0, 5'd0, '0);
    step();
    chk("x0_read", 64'(r1[0]), 64'd0);
    chk("x0_nobyp", 64'(r1[1]), 64'd0);

    if_instr = 32'h0010_8A13;
    step();
    chk("e_ctrl", 64'(c[2]), 64'd0);
    chk("e_valid", 64'(v[2]), 64'd1);
    chk("i_ctrl", 64'(c[0]), 64'(k_addi));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
